// File: rtl/div_pkg.sv
// Shared definitions for the divide-ratio controller.
//   state_e      : controller FSM state (IDLE, RUN, PEND, STOP)
//   CNT_W_DEF    : default width of ratio and phase counter
//   MIN_DIV_DEF  : default smallest legal divide ratio
//   DEF_DIV_DEF  : default ratio after reset
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        PEND = ST_PEND,
        STOP = ST_STOP
    } state_e;

    localparam int CNT_W_DEF   = 8;
    localparam int MIN_DIV_DEF = 2;
    localparam int DEF_DIV_DEF = 4;

endpackage

// File: rtl/div_phase_cnt.sv
// Phase counter and divided-waveform generator.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   ratio_i      : ratio of the period in progress (defines the wrap point)
//   ratio_nxt_i  : ratio that will be active next cycle (defines the waveform shape)
//   run_i        : counter is active next cycle
//   restart_i    : force the counter to phase 0 (period start from idle)
//   last_o       : current cycle is the last of the period (cnt == ratio-1)
//   clk_div_o    : registered divided output
//   tick_o       : registered 1-cycle pulse on every period start
module div_phase_cnt
    import div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] ratio_i,
    input  logic [CNT_W-1:0] ratio_nxt_i,
    input  logic             run_i,
    input  logic             restart_i,
    output logic             last_o,
    output logic             clk_div_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    assign last_o = (cnt_q == ratio_i - CNT_W'(1));

    // Outputs are registered from the next phase value so clk_div/tick line up
    // with cnt; the shape uses the ratio that is active in that next cycle, so a
    // ratio change at the boundary starts cleanly with a high phase.
    always_comb begin
        cnt_d = '0;
        if (run_i && !restart_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        clk_div_d = run_i && (cnt_d < (ratio_nxt_i >> 1));
        tick_d    = run_i && (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div_o = clk_div_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time controller for the square-wave clock divider. Owns the active divide
// ratio, takes new ratios over a valid/ready port and applies them only at a
// period boundary; starts/stops the divided output cleanly on en.
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   en         : 1 = run, 0 = stop at the end of the current period
//   cfg_valid  : new ratio offered
//   cfg_ready  : ratio can be accepted (IDLE or RUN)
//   cfg_div    : requested ratio
//   clk_div    : divided output
//   tick       : 1-cycle pulse when clk_div rises
//   locked     : running at the active ratio with no change pending
//   err_ratio  : 1-cycle pulse when an accepted ratio was below MIN_DIV
//
// state | meaning
// IDLE  | output parked low, ratio may be loaded directly
// RUN   | waveform running at the active ratio, config accepted
// PEND  | waveform running, new ratio waits for the period boundary
// STOP  | finishing the current period, then back to IDLE
module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_div,
    output logic             tick,
    output logic             locked,
    output logic             err_ratio
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             locked_q, err_q;
    logic             accept, bad_div, last;

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign bad_div   = (cfg_div < CNT_W'(MIN_DIV));

    always_comb begin
        state_d    = state_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            IDLE: begin
                if (accept && !bad_div) ratio_d = cfg_div;
                if (en) state_d = RUN;
            end
            RUN: begin
                // An accept on the last cycle still waits a full period: the
                // boundary being taken now belongs to the old ratio.
                if (accept && !bad_div) begin
                    pend_d     = cfg_div;
                    pend_vld_d = 1'b1;
                    state_d    = en ? PEND : STOP;
                end else if (!en) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (last) begin
                    ratio_d    = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = en ? RUN : STOP;
                end
            end
            STOP: begin
                if (last) begin
                    if (pend_vld_q) ratio_d = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ratio_q    <= CNT_W'(DEF_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            locked_q   <= (state_d == RUN);
            err_q      <= accept && bad_div;
        end
    end

    div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ratio_i     (ratio_q),
        .ratio_nxt_i (ratio_d),
        .run_i       (state_d != IDLE),
        .restart_i   (state_q == IDLE),
        .last_o      (last),
        .clk_div_o   (clk_div),
        .tick_o      (tick)
    );

    assign locked    = locked_q;
    assign err_ratio = err_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
module tb_div_ratio_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int MIN_DIV = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready, clk_div, tick, locked, err_ratio;

    always #5 clk = ~clk;

    div_ratio_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV),
        .MIN_DIV (MIN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .clk_div   (clk_div),
        .tick      (tick),
        .locked    (locked),
        .err_ratio (err_ratio)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the period, active ratio, pending
    // ratio (0 = none) and whether a stop has been requested.
    bit m_run = 0, m_stop = 0, m_err = 0;
    int m_pos = 0, m_ratio = DEF_DIV, m_pend = 0;
    bit chk_on = 0;
    bit mv_acc, mv_good, mv_bnd, mv_was_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_stop = 0; m_err = 0;
            m_pos = 0; m_ratio = DEF_DIV; m_pend = 0;
        end else begin
            mv_acc  = cfg_valid && !m_stop && (m_pend == 0);
            m_err   = mv_acc && (int'(cfg_div) < MIN_DIV);
            mv_good = mv_acc && !m_err;
            if (!m_run) begin
                if (mv_good) m_ratio = int'(cfg_div);
                if (en) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else begin
                mv_bnd      = (m_pos == m_ratio - 1);
                mv_was_pend = (m_pend != 0);
                m_pos       = mv_bnd ? 0 : m_pos + 1;
                if (m_stop) begin
                    if (mv_bnd) begin
                        if (mv_was_pend) m_ratio = m_pend;
                        m_pend = 0; m_run = 0; m_stop = 0;
                    end
                end else if (mv_was_pend) begin
                    if (mv_bnd) begin
                        m_ratio = m_pend;
                        m_pend  = 0;
                        if (!en) m_stop = 1;
                    end
                end else begin
                    if (mv_good) m_pend = int'(cfg_div);
                    if (!en) m_stop = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_clk_div",   32'(clk_div),   32'(m_run && (m_pos < m_ratio / 2)));
            check("m_tick",      32'(tick),      32'(m_run && (m_pos == 0)));
            check("m_locked",    32'(locked),    32'(m_run && !m_stop && (m_pend == 0)));
            check("m_err_ratio", 32'(err_ratio), 32'(m_err));
            check("m_cfg_ready", 32'(cfg_ready), 32'(!m_stop && (m_pend == 0)));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic collect(int n, output logic [31:0] cd, output logic [31:0] tk);
        cd = '0;
        tk = '0;
        for (int i = 0; i < n; i++) begin
            step();
            cd[i] = clk_div;
            tk[i] = tick;
        end
    endtask

    logic [31:0] cd, tk;

    initial begin
        step();
        chk_on = 1;

        // 1: default ratio 4
        do_reset();
        check("t1_rst_clk_div", 32'(clk_div), 32'd0);
        check("t1_rst_ready",   32'(cfg_ready), 32'd1);
        check("t1_rst_locked",  32'(locked), 32'd0);
        en = 1'b1;
        collect(8, cd, tk);
        check("t1_wave", cd, 32'h33);
        check("t1_tick", tk, 32'h11);
        check("t1_locked", 32'(locked), 32'd1);

        // 2: load 5 in IDLE then run
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0; en = 1'b1;
        collect(10, cd, tk);
        check("t2_wave", cd, 32'h63);
        check("t2_tick", tk, 32'h21);

        // 3: change 4 -> 6 mid-period
        do_reset();
        en = 1'b1;
        step(); step();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        check("t3_pend_ready",  32'(cfg_ready), 32'd0);
        check("t3_pend_locked", 32'(locked), 32'd0);
        collect(7, cd, tk);
        check("t3_wave", cd, 32'h0E);
        check("t3_tick", tk, 32'h02);
        check("t3_locked", 32'(locked), 32'd1);
        check("t3_ready",  32'(cfg_ready), 32'd1);

        // 4: illegal ratio
        do_reset();
        en = 1'b1;
        step(); step();
        cfg_valid = 1'b1; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        check("t4_err",   32'(err_ratio), 32'd1);
        check("t4_ready", 32'(cfg_ready), 32'd1);
        step();
        check("t4_err_off", 32'(err_ratio), 32'd0);
        collect(8, cd, tk);
        check("t4_wave", cd, 32'h33);

        // 5: stop at N=8
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd8;
        step();
        cfg_valid = 1'b0; en = 1'b1;
        step();
        en = 1'b0;
        collect(9, cd, tk);
        check("t5_wave",   cd, 32'h07);
        check("t5_ready",  32'(cfg_ready), 32'd1);
        check("t5_locked", 32'(locked), 32'd0);

        // 6: reset during high phase at N=6
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0; en = 1'b1;
        step(); step();
        rst_n = 1'b0;
        step();
        check("t6_rst_clk_div", 32'(clk_div), 32'd0);
        check("t6_rst_ready",   32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        collect(8, cd, tk);
        check("t6_wave", cd, 32'h33);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 25))
                                                     : CNT_W'($urandom_range(0, 9));
            rst_n     = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
